// File: rtl/ysyx_22050058_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050058_ctrl_if
// Purpose  : Bundle of the pipeline-control signals exchanged between the
//            stage logic (master) and the control block (slave).
// Params   : ADDR_W - width of PC / jump address
//            CNT_W  - width of performance counters
// Signals  : if/id/ex/mem_stall_req_i  stage hold requests
//            ex_instvalid_i, ex_isjump_i, ex_jumpaddr_i  EX branch outcome
//            stall_o[4:0], flush_o[4:0]  per-register hold / bubble enables
//            redirect_valid_o, redirect_pc_o, redirect_pending_o  PC redirect
//            stall_cycles_o, redirect_count_o  performance counters
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_22050058_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              if_stall_req_i;
  logic              id_stall_req_i;
  logic              ex_stall_req_i;
  logic              mem_stall_req_i;
  logic              ex_instvalid_i;
  logic              ex_isjump_i;
  logic [ADDR_W-1:0] ex_jumpaddr_i;
  logic [4:0]        stall_o;
  logic [4:0]        flush_o;
  logic              redirect_valid_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              redirect_pending_o;
  logic [CNT_W-1:0]  stall_cycles_o;
  logic [CNT_W-1:0]  redirect_count_o;

  modport master (
    output if_stall_req_i, id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
    output ex_instvalid_i, ex_isjump_i, ex_jumpaddr_i,
    input  stall_o, flush_o, redirect_valid_o, redirect_pc_o,
    input  redirect_pending_o, stall_cycles_o, redirect_count_o
  );

  modport slave (
    input  if_stall_req_i, id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
    input  ex_instvalid_i, ex_isjump_i, ex_jumpaddr_i,
    output stall_o, flush_o, redirect_valid_o, redirect_pc_o,
    output redirect_pending_o, stall_cycles_o, redirect_count_o
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050058_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050058_ctrl
// Purpose  : Pipeline control for the five-stage core. Decodes stage stall
//            requests into per-register hold/bubble vectors, turns a taken
//            EX branch into a PC redirect (deferred while the PC is frozen)
//            and counts stall cycles and delivered redirects.
// Ports    : clk   - core clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - ysyx_22050058_ctrl_if.slave (stage requests in,
//                    stall/flush/redirect/counters out)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050058_ctrl #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_22050058_ctrl_if.slave       bus
);

  logic [4:0]        w_stall_raw;
  logic [4:0]        w_flush_raw;
  logic [4:0]        w_flush;
  logic [4:0]        w_stall;
  logic              w_fire;
  logic              w_deliver;
  logic [ADDR_W-1:0] w_redirect_pc;

  logic              r_pending;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_redirect_count;

  // Deepest requester wins: it holds every register upstream of it and
  // bubbles the register directly downstream.
  always_comb begin
    w_stall_raw = 5'b00000;
    w_flush_raw = 5'b00000;
    if (bus.mem_stall_req_i) begin
      w_stall_raw = 5'b01111;
      w_flush_raw = 5'b10000;
    end else if (bus.ex_stall_req_i) begin
      w_stall_raw = 5'b00111;
      w_flush_raw = 5'b01000;
    end else if (bus.id_stall_req_i) begin
      w_stall_raw = 5'b00011;
      w_flush_raw = 5'b00100;
    end else if (bus.if_stall_req_i) begin
      w_stall_raw = 5'b00001;
      w_flush_raw = 5'b00010;
    end
  end

  // The EX instruction is held whenever ID/EX is held (EX or MEM stall); a
  // held jump must not redirect. The raw decode is used here because the
  // final stall vector itself depends on the fire-driven flush.
  assign w_fire = bus.ex_isjump_i & bus.ex_instvalid_i & ~w_stall_raw[2];

  // Fire kills IF/ID and ID/EX; a waiting redirect keeps killing IF/ID so
  // wrong-path fetches never reach decode. Flush overrides hold per bit.
  assign w_flush = w_flush_raw | {2'b00, w_fire, w_fire | r_pending, 1'b0};
  assign w_stall = w_stall_raw & ~w_flush;

  // A live fire carries a newer target than anything latched.
  assign w_redirect_pc = w_fire    ? bus.ex_jumpaddr_i :
                         r_pending ? r_redirect_pc     : '0;

  assign w_deliver = (w_fire | r_pending) & ~w_stall[0];

  assign bus.stall_o            = w_stall;
  assign bus.flush_o            = w_flush;
  assign bus.redirect_valid_o   = w_fire | r_pending;
  assign bus.redirect_pc_o      = w_redirect_pc;
  assign bus.redirect_pending_o = r_pending;
  assign bus.stall_cycles_o     = r_stall_cycles;
  assign bus.redirect_count_o   = r_redirect_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending        <= 1'b0;
      r_redirect_pc    <= '0;
      r_stall_cycles   <= '0;
      r_redirect_count <= '0;
    end else begin
      // Any edge where the PC advances consumes the redirect (pending or a
      // same-cycle fire); otherwise a fire parks its target here.
      if (!w_stall[0]) begin
        r_pending <= 1'b0;
      end else if (w_fire) begin
        r_pending     <= 1'b1;
        r_redirect_pc <= bus.ex_jumpaddr_i;
      end

      if ((|w_stall) && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end

      if (w_deliver) begin
        r_redirect_count <= r_redirect_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
